// File: rtl/seq_div_engine_pkg.sv
// Shared definitions for the sequential divider slice.
// Provides the FSM state type and the width, counter and latency constants.
// Optional feature macro used elsewhere in this slice: SEQ_DIV_UNSIGNED_EN.
package div_pkg;

  localparam int unsigned DIV_WIDTH   = 32;
  localparam int unsigned DIV_CNT_W   = 6;
  // Edges from the accepting edge up to and including the edge that raises done.
  localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_div_engine_if.sv
// Request/response bundle between the control unit and the divider.
//   master (control unit): drives start, dividend, divisor [, is_unsigned]
//   slave  (divider)     : drives busy, done, div_by_zero, quotient, remainder
// With SEQ_DIV_UNSIGNED_EN defined, an is_unsigned request bit is added.
interface seq_div_engine_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIV_UNSIGNED_EN
  logic             is_unsigned;
`endif
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
`ifdef SEQ_DIV_UNSIGNED_EN
    output is_unsigned,
`endif
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
`ifdef SEQ_DIV_UNSIGNED_EN
    input  is_unsigned,
`endif
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );

endinterface

// File: rtl/seq_div_engine_sign_fix.sv
// Combinational conditional two's-complement negation (module div_sign_fix).
// Used to take operand magnitudes and to restore the sign of the results.
//   value  : input operand
//   negate : when high, result = -value; otherwise result = value
//   result : output
module div_sign_fix
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  // -(most negative) wraps to itself, which is exactly its unsigned magnitude.
  always_comb begin
    result = negate ? -value : value;
  end

endmodule

// File: rtl/seq_div_engine.sv
// Multicycle restoring divider (MIPS div semantics: quotient truncates toward
// zero, remainder takes the dividend's sign). One quotient bit per clock.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of seq_div_engine_if (start/operands in,
//                busy/done/div_by_zero/quotient/remainder out)
// Optional: SEQ_DIV_UNSIGNED_EN adds bus.is_unsigned (divu, no sign handling).
module seq_div_engine
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  seq_div_engine_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             is_uns;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] quo_fixed, rem_fixed;
  logic [WIDTH:0]   shifted, trial;

`ifdef SEQ_DIV_UNSIGNED_EN
  assign is_uns = bus.is_unsigned;
`else
  assign is_uns = 1'b0;
`endif

  assign neg_a = bus.dividend[WIDTH-1] & ~is_uns;
  assign neg_b = bus.divisor[WIDTH-1] & ~is_uns;

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .value  (bus.dividend),
    .negate (neg_a),
    .result (mag_a)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .value  (bus.divisor),
    .negate (neg_b),
    .result (mag_b)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .value  (quo_q),
    .negate (sign_a_q ^ sign_b_q),
    .result (quo_fixed)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .value  (rem_q),
    .negate (sign_a_q),
    .result (rem_fixed)
  );

  // quo_q starts as |dividend| and shifts its bits into rem_q MSB first while
  // quotient bits fill in from the bottom.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    dbz_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Flag only; result registers keep the previous answer.
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else begin
            quo_d    = mag_a;
            dvs_d    = mag_b;
            sign_a_d = neg_a;
            sign_b_d = neg_b;
            rem_d    = '0;
            cnt_d    = '0;
            state_d  = StRun;
          end
        end
      end
      StRun: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        quotient_d  = quo_fixed;
        remainder_d = rem_fixed;
        done_d      = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;

endmodule

// File: tb/tb_seq_div_engine.sv
// Scoreboard bench for seq_div_engine: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever done is seen.
module tb_seq_div_engine;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  seq_div_engine_if #(.WIDTH(W)) bus ();

  seq_div_engine #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_done: done seen at edge %0d with nothing expected", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
        check("done_edge", 32'(cyc), 32'(e.cyc));
        check("busy_at_done", {31'b0, bus.busy}, 32'd0);
      end
    end
  end

  // Entered at a negedge; the request is taken at the next rising edge k.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                       input logic [W-1:0] r, input logic dbz, input bit push);
    int k;
    k = cyc + 1;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) sb.push_back('{q: q, r: r, dbz: dbz, cyc: (dbz ? k : k + W + 1)});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt);
    int n;
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < 60) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      n_checks++;
      $display("FAIL done_timeout: no done within 60 cycles, got busy=%0b required done=1", bus.busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    n_checks = 0;
    n_pass   = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef SEQ_DIV_UNSIGNED_EN
    bus.is_unsigned = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 7 / 2 with busy-duration check
    issue(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b1);
    wait_done(bc);
    check("busy_cycles", 32'(bc), 32'd33);
    @(negedge clk);
    check("done_one_cycle", {31'b0, bus.done}, 32'd0);

    // Sign combinations
    issue(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_done(bc);
    @(negedge clk);
    issue(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1);
    wait_done(bc);
    @(negedge clk);

    // Restore 3/1, then divide by zero keeps it
    issue(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b1);
    wait_done(bc);
    @(negedge clk);
    issue(32'd123, 32'd0, 32'd3, 32'd1, 1'b1, 1'b1);
    wait_done(bc);
    check("dbz_busy_cycles", 32'(bc), 32'd0);
    @(negedge clk);
    check("dbz_busy_after", {31'b0, bus.busy}, 32'd0);
    check("dbz_done_once", {31'b0, bus.done}, 32'd0);

    // Overflow case
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    wait_done(bc);
    @(negedge clk);

    // start while busy is ignored
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    issue(32'd9, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_done(bc);
    repeat (40) @(negedge clk);

    // start accepted in the cycle done is high
    issue(32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 1'b1);
    wait_done(bc);
    issue(32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 1'b1);
    check("b2b_busy", {31'b0, bus.busy}, 32'd1);
    wait_done(bc);
    @(negedge clk);

`ifdef SEQ_DIV_UNSIGNED_EN
    bus.is_unsigned = 1'b1;
    issue(32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b1);
    bus.is_unsigned = 1'b0;
    wait_done(bc);
    @(negedge clk);
`endif

    // Reset mid-operation aborts without done
    issue(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_quotient", bus.quotient, 32'd0);
    check("abort_remainder", bus.remainder, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
    wait_done(bc);

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_div_engine.md
Name: seq_div_engine

Overview:
Multicycle signed 32-bit divider that answers the control unit's divide request (the DIV_on start pulse with the A/B operands). It returns the quotient for Lo, the remainder for Hi, and a divide-by-zero flag the control unit uses to raise the exception path. It is the responder side of the start/done handshake. The control unit waits in its DIV wait state until done, then asserts Hi_write/Lo_write.

Parameters:
WIDTH, 32, operand/result width in bits (the CPU uses only 32).
CNT_W, 6, iteration-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
start  input  1  request pulse from the control unit; sampled only in IDLE
dividend  input  WIDTH  operand A (A_out), two's complement
divisor  input  WIDTH  operand B (B_out), two's complement
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
div_by_zero  output  1  high together with done when divisor was 0
quotient  output  WIDTH  to the Lo source mux
remainder  output  WIDTH  to the Hi source mux

Behaviour:
- One clock domain.
- Reset is synchronous and active-high: the clock is clk, the reset is reset, and the polarity and synchronicity are fixed.
- Reset values: state=IDLE, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, internal registers=0.
- States: IDLE, RUN, FIX.
- IDLE + start + divisor!=0, at edge k:
  - latch |dividend| and |divisor|, and both sign bits;
  - clear the partial remainder; counter=0; busy=1; go to RUN.
- IDLE + start + divisor==0, at edge k:
  - done=1 and div_by_zero=1 for exactly one cycle; state stays IDLE;
  - quotient and remainder keep their previous values; busy stays 0.
- RUN, each edge: one restoring step.
  - Shift {rem, quo} left by 1.
  - Trial subtract rem - |divisor| (WIDTH+1 bits).
  - If the result is non-negative, keep it and set quo[0]=1.
  - counter++. After WIDTH steps (edge k+WIDTH) go to FIX.
- FIX, at edge k+WIDTH+1:
  - quotient = (sign_a^sign_b) ? -quo : quo;
  - remainder = sign_a ? -rem : rem;
  - done=1 for one cycle, div_by_zero=0, busy=0, go to IDLE.
- Latency: done is visible in the cycle after edge k+WIDTH+1, i.e. 34 edges for WIDTH=32.
- Semantics: quotient truncates toward zero; remainder takes the dividend's sign (MIPS div).
- Overflow case 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, no flag. Magnitudes are handled as WIDTH-bit unsigned.
- start while busy (RUN/FIX): ignored. Operands are not re-sampled, so the in-flight result is unaffected.
- start in the same cycle done is high: accepted, because the state is already IDLE.
- done is never asserted twice per request. Outputs hold their value until the next completion.
- reset mid-operation: abort, return to IDLE, all outputs to their reset values; no done is produced.

Optional Feature:
Macro SEQ_DIV_UNSIGNED_EN.
- Defined: adds input port is_unsigned (1 bit), sampled with start.
  - When is_unsigned is high, sign handling is bypassed: operands are taken as raw values and the FIX state does no negation (MIPS divu).
  - The divide-by-zero rule is unchanged.
- Undefined: no port; signed division only; behaviour exactly as above.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, RUN, FIX);
  - DIV_WIDTH=32 and DIV_CNT_W=6 constants;
  - latency constant DIV_LATENCY=DIV_WIDTH+2.
- Sub-module div_sign_fix: combinational abs/negate helper, used for operand magnitude at start and for result sign correction in FIX.
- The iteration datapath stays in seq_div_engine.

Test Plan:
- dividend=7, divisor=2, start pulse → after 34 edges: done=1 for one cycle, quotient=3, remainder=1, div_by_zero=0; busy high for edges 1..33.
- dividend=-7 (0xFFFFFFF9), divisor=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also 7/-2 → quotient=0xFFFFFFFD, remainder=1.
- Any dividend, divisor=0 → next cycle: done=1, div_by_zero=1, busy never asserted; quotient and remainder unchanged from the prior result (e.g. still 3/1).
- 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, div_by_zero=0.
- Start 100/7; pulse start again at edge 5 with 9/3 → single done at edge 34 with quotient=14, remainder=2; no second done.
- Start 100/7; assert reset at edge 10 → next cycle busy=0, done=0, quotient=0, remainder=0. A new start 9/3 then yields quotient=3, remainder=0 after 34 edges.
